// File: rtl/io_pkg.sv
// io_pkg: shared constants for the memory-mapped IO bridge.
// Holds the IO page base, register offsets and default parameter values.
package io_pkg;

    localparam logic [19:0] IO_BASE    = 20'hFFFFF;

    localparam logic [11:0] OFF_DIGIT  = 12'h000;
    localparam logic [11:0] OFF_TIMER  = 12'h020;
    localparam logic [11:0] OFF_LED    = 12'h060;
    localparam logic [11:0] OFF_SWITCH = 12'h070;

    localparam int SW_W         = 24;
    localparam int DEBOUNCE_DEF = 20000;
    localparam int TICK_DIV_DEF = 25000;

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchronizer plus optional debounce of a switch bus.
// Ports: clk, rst (sync active-low), raw_i (async bus), stable_o (accepted).
// Macro IO_DEBOUNCE_EN enables the stability counter; otherwise the
// accepted value is the synchronized value.
module sw_debounce
    import io_pkg::*;
#(
    parameter int W      = SW_W,
    parameter int CYCLES = DEBOUNCE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] stable_o
);

    logic [W-1:0] sync1_q;
    logic [W-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;

    // Count consecutive cycles of disagreement; any agreement restarts.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (sync2_q == acc_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(CYCLES - 1)) begin
            acc_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    assign stable_o = acc_q;
`else
    assign stable_o = sync2_q;
`endif

endmodule

// File: rtl/io_bridge.sv
// io_bridge: splits MEM-stage accesses between data RAM and an IO page.
// Ports: clk, rst (sync active-low), we/adr/wdata/rdata (CPU side),
// dram_we/dram_rd (RAM side), switch (raw in), led, digit (outputs).
// Macro IO_DEBOUNCE_EN enables switch debouncing in sw_debounce.
module io_bridge
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int TICK_DIV        = TICK_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        dram_we,
    input  logic [31:0] dram_rd,
    input  logic [23:0] switch,
    output logic [23:0] led,
    output logic [31:0] digit
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic        is_io;
    logic [11:0] off;
    logic        io_wr;
    logic        tick;

    logic [31:0] digit_q, digit_d;
    logic [23:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [23:0] sw_acc;

    assign is_io   = (adr[31:12] == IO_BASE);
    assign off     = adr[11:0];
    assign io_wr   = we & is_io;
    assign dram_we = we & ~is_io;

    sw_debounce #(
        .W      (SW_W),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_sw (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (switch),
        .stable_o (sw_acc)
    );

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    // CPU timer write wins over a same-cycle tick.
    always_comb begin
        digit_d = digit_q;
        led_d   = led_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        timer_d = tick ? timer_q + 32'd1 : timer_q;
        if (io_wr) begin
            case (off)
                OFF_DIGIT: digit_d = wdata;
                OFF_TIMER: begin
                    timer_d = wdata;
                    presc_d = '0;
                end
                OFF_LED:   led_d = wdata[23:0];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            digit_q <= '0;
            led_q   <= '0;
            timer_q <= '0;
            presc_q <= '0;
        end else begin
            digit_q <= digit_d;
            led_q   <= led_d;
            timer_q <= timer_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        rdata = dram_rd;
        if (is_io) begin
            case (off)
                OFF_DIGIT:  rdata = digit_q;
                OFF_TIMER:  rdata = timer_q;
                OFF_LED:    rdata = {8'h00, led_q};
                OFF_SWITCH: rdata = {8'h00, sw_acc};
                default:    rdata = '0;
            endcase
        end
    end

    assign led   = led_q;
    assign digit = digit_q;

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed scoreboard bench for io_bridge.
// Built with TICK_DIV=4 and DEBOUNCE_CYCLES=8.
module tb_io_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] dram_rd = '0;
    logic [23:0] switch = '0;
    logic [31:0] rdata;
    logic        dram_we;
    logic [23:0] led;
    logic [31:0] digit;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    io_bridge #(
        .DEBOUNCE_CYCLES (8),
        .TICK_DIV        (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .adr     (adr),
        .wdata   (wdata),
        .rdata   (rdata),
        .dram_we (dram_we),
        .dram_rd (dram_rd),
        .switch  (switch),
        .led     (led),
        .digit   (digit)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        we  = 1'b0;
        adr = a;
        #1;
    endtask

    initial begin
        // reset held for two edges
        adr = 32'hFFFFF020;
        step(2);
        push(32'h0); pop_check("rst_led", {8'h0, led});
        push(32'h0); pop_check("rst_digit", digit);
        push(32'h0); pop_check("rst_timer", rdata);

        // timer free-run from reset release
        rst = 1'b1;
        step(11);
        push(32'd2); pop_check("timer_11", rdata);
        step(1);
        push(32'd3); pop_check("timer_12", rdata);

        // timer load and wrap
        we    = 1'b1;
        wdata = 32'hFFFFFFFF;
        step(1);
        we = 1'b0;
        push(32'hFFFFFFFF); pop_check("timer_load", rdata);
        step(3);
        push(32'hFFFFFFFF); pop_check("timer_hold", rdata);
        step(1);
        push(32'h0); pop_check("timer_wrap", rdata);

        // LED write
        we    = 1'b1;
        adr   = 32'hFFFFF060;
        wdata = 32'hAB123456;
        #1;
        push(32'h0); pop_check("led_dwe_w", {31'h0, dram_we});
        push(32'h0); pop_check("led_old_rd", rdata);
        step(1);
        we = 1'b0;
        #1;
        push(32'h00123456); pop_check("led_out", {8'h0, led});
        push(32'h00123456); pop_check("led_rd", rdata);
        push(32'h0); pop_check("led_dwe_r", {31'h0, dram_we});

        // digit write
        we    = 1'b1;
        adr   = 32'hFFFFF000;
        wdata = 32'h12345678;
        step(1);
        rd(32'hFFFFF000);
        push(32'h12345678); pop_check("digit_out", digit);
        push(32'h12345678); pop_check("digit_rd", rdata);

        // DRAM pass-through
        we    = 1'b1;
        adr   = 32'h00004010;
        wdata = 32'h55555555;
        #1;
        push(32'h1); pop_check("dram_we", {31'h0, dram_we});
        step(1);
        we      = 1'b0;
        dram_rd = 32'hDEADBEEF;
        #1;
        push(32'hDEADBEEF); pop_check("dram_rd", rdata);
        push(32'h0); pop_check("dram_we_off", {31'h0, dram_we});
        push(32'h00123456); pop_check("dram_led", {8'h0, led});
        rd(32'hFFFFF060);
        push(32'h00123456); pop_check("io_not_dram", rdata);

        // unmapped IO
        rd(32'hFFFFF044);
        push(32'h0); pop_check("unmap_rd", rdata);
        we    = 1'b1;
        wdata = 32'hFFFFFFFF;
        step(1);
        we = 1'b0;
        #1;
        push(32'h00123456); pop_check("unmap_led", {8'h0, led});
        push(32'h12345678); pop_check("unmap_digit", digit);

        // switch path
        rd(32'hFFFFF070);
`ifdef IO_DEBOUNCE_EN
        switch = 24'h000001;
        step(3);
        switch = 24'h000000;
        step(20);
        push(32'h0); pop_check("sw_glitch", rdata);
        switch = 24'h000001;
        step(9);
        push(32'h0); pop_check("sw_early", rdata);
        step(1);
        push(32'h1); pop_check("sw_accept", rdata);
`else
        switch = 24'h000001;
        step(1);
        push(32'h0); pop_check("sw_sync1", rdata);
        step(1);
        push(32'h1); pop_check("sw_sync2", rdata);
        switch = 24'hA5A5A5;
        step(2);
        push(32'h00A5A5A5); pop_check("sw_pat", rdata);
        switch = 24'h000001;
        step(2);
`endif

        // switch register is read-only
        we    = 1'b1;
        wdata = 32'h0;
        step(1);
        we = 1'b0;
        #1;
        push(32'h1); pop_check("sw_ro", rdata);

        // reset overrides a simultaneous write
        rst   = 1'b0;
        we    = 1'b1;
        adr   = 32'hFFFFF060;
        wdata = 32'hFFFFFFFF;
        #1;
        push(32'h0); pop_check("rstw_dwe_io", {31'h0, dram_we});
        step(1);
        push(32'h0); pop_check("rstw_led", {8'h0, led});
        push(32'h0); pop_check("rstw_digit", digit);
        adr = 32'h00004010;
        #1;
        push(32'h1); pop_check("rstw_dwe_ram", {31'h0, dram_we});
        we  = 1'b0;
        rst = 1'b1;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
